serializer_arbiter: RTL and testbench



---
 rtl/serializer_pkg.sv | 23 ++
 rtl/rr_pick.sv | 31 +++
 rtl/serializer_arbiter.sv | 127 ++++++++++++
 tb/tb_serializer_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serializer arbiter slice.
// Holds the FSM state encoding and width helpers.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Finds the first set request at or above ptr, wrapping around.
import serializer_pkg::*;

module rr_pick #(
  parameter int N = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  int j;

  // Walk offsets downward so the smallest offset wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sharing one serializer between requesters.
// Loads a word, shifts it for WIDTH cycles, then idles GAP_CYCLES.
import serializer_pkg::*;

module serializer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     in_clock,
  input  logic                     in_reset_n,
  input  logic [NUM_REQ-1:0]       in_req,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       out_ack,
  output logic [NUM_REQ-1:0]       out_done,
  output logic                     out_busy,
  output logic                     out_ser_write,
  output logic [WIDTH-1:0]         out_ser_data,
  output logic                     out_ser_enable
);

  localparam int PW = clog2(NUM_REQ);
  localparam int CW = (clog2(WIDTH) > 4) ? clog2(WIDTH) : 4;
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               pick_v;
  logic [PW-1:0]      pick_i;

  logic [NUM_REQ-1:0] ack_d, done_d;
  logic               busy_d, wr_d, en_d;
  logic [WIDTH-1:0]   data_d;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (in_req),
    .ptr  (ptr_q),
    .valid(pick_v),
    .idx  (pick_i)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          gidx_d  = pick_i;
          word_d  = in_data[int'(pick_i)*WIDTH +: WIDTH];
          state_d = LOAD;
          if (int'(pick_i) == NUM_REQ - 1) ptr_d = '0;
          else ptr_d = pick_i + 1'b1;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = CW'(WIDTH - 1);
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CW'(GL);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops.
  always_comb begin
    ack_d  = '0;
    done_d = '0;
    wr_d   = (state_d == LOAD);
    en_d   = (state_d == SHIFT);
    busy_d = (state_d != IDLE);
    data_d = (state_d == LOAD) ? word_d : '0;
    if (state_d == LOAD) ack_d[gidx_d] = 1'b1;
    if (state_d == SHIFT && cnt_d == '0) done_d[gidx_d] = 1'b1;
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gidx_q         <= '0;
      cnt_q          <= '0;
      word_q         <= '0;
      out_ack        <= '0;
      out_done       <= '0;
      out_busy       <= 1'b0;
      out_ser_write  <= 1'b0;
      out_ser_data   <= '0;
      out_ser_enable <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gidx_q         <= gidx_d;
      cnt_q          <= cnt_d;
      word_q         <= word_d;
      out_ack        <= ack_d;
      out_done       <= done_d;
      out_busy       <= busy_d;
      out_ser_write  <= wr_d;
      out_ser_data   <= data_d;
      out_ser_enable <= en_d;
    end
  end

endmodule

// File: tb/tb_serializer_arbiter.sv
// Bench for serializer_arbiter: frame-position model plus directed tests.
// Instance 0 uses GAP_CYCLES=1, instance 1 uses GAP_CYCLES=0.
module tb_serializer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req  [2];
  logic [N*W-1:0] dat  [2];
  logic [N-1:0]   ack  [2];
  logic [N-1:0]   done [2];
  logic           busy [2];
  logic           wr   [2];
  logic           en   [2];
  logic [W-1:0]   sdat [2];

  serializer_arbiter #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(1)) u0 (
    .in_clock(clk), .in_reset_n(rst_n), .in_req(req[0]),
    .in_data(dat[0]), .out_ack(ack[0]), .out_done(done[0]),
    .out_busy(busy[0]), .out_ser_write(wr[0]),
    .out_ser_data(sdat[0]), .out_ser_enable(en[0])
  );

  serializer_arbiter #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(0)) u1 (
    .in_clock(clk), .in_reset_n(rst_n), .in_req(req[1]),
    .in_data(dat[1]), .out_ack(ack[1]), .out_done(done[1]),
    .out_busy(busy[1]), .out_ser_write(wr[1]),
    .out_ser_data(sdat[1]), .out_ser_enable(en[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: position within the current frame (0 = idle).
  int         pos [2];
  int         mg  [2];
  int         mp  [2];
  logic [W-1:0] mw [2];

  int alog0[$], alog1[$], dlog0[$], dlog1[$], glog0[$], glog1[$];
  logic [W-1:0] ackw0[$], ackw1[$];
  int  lowrun [2];
  bit  seen   [2];
  bit  clr;
  bit  auto_on;
  logic [N-1:0] want;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int gapof(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int pickm(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pos[d] = 0; mg[d] = 0; mp[d] = 0; mw[d] = '0;
      end else if (pos[d] == 0) begin
        if (req[d] != '0) begin
          mg[d]  = pickm(req[d], mp[d]);
          mp[d]  = (mg[d] + 1) % N;
          mw[d]  = dat[d][mg[d]*W +: W];
          pos[d] = 1;
        end
      end else begin
        pos[d]++;
        if (pos[d] > W + 1 + gapof(d)) pos[d] = 0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] ea, ed;
      ea = '0;
      ed = '0;
      if (pos[d] == 1) ea[mg[d]] = 1'b1;
      if (pos[d] == W + 1) ed[mg[d]] = 1'b1;
      chk($sformatf("d%0d_ack", d), 32'(ack[d]), 32'(ea));
      chk($sformatf("d%0d_done", d), 32'(done[d]), 32'(ed));
      chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(pos[d] != 0));
      chk($sformatf("d%0d_write", d), 32'(wr[d]), 32'(pos[d] == 1));
      chk($sformatf("d%0d_data", d), 32'(sdat[d]),
          32'((pos[d] == 1) ? mw[d] : '0));
      chk($sformatf("d%0d_enable", d), 32'(en[d]),
          32'(pos[d] >= 2 && pos[d] <= W + 1));
    end
    if (clr) begin
      alog0 = {}; alog1 = {}; dlog0 = {}; dlog1 = {};
      glog0 = {}; glog1 = {}; ackw0 = {}; ackw1 = {};
      lowrun[0] = 0; lowrun[1] = 0; seen[0] = 0; seen[1] = 0;
    end
    if (ack[0] != '0) begin alog0.push_back(oh(ack[0])); ackw0.push_back(sdat[0]); end
    if (ack[1] != '0) begin alog1.push_back(oh(ack[1])); ackw1.push_back(sdat[1]); end
    if (done[0] != '0) dlog0.push_back(oh(done[0]));
    if (done[1] != '0) dlog1.push_back(oh(done[1]));
    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        if (seen[d] && lowrun[d] > 0) begin
          if (d == 0) glog0.push_back(lowrun[d]);
          else glog1.push_back(lowrun[d]);
        end
        seen[d] = 1;
        lowrun[d] = 0;
      end else begin
        lowrun[d]++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (auto_on) begin
      for (int i = 0; i < N; i++) begin
        if (ack[0][i]) req[0][i] = 1'b0;
        else if (want[i]) req[0][i] = 1'b1;
      end
    end
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
  endtask

  task automatic wait_acks(input int d, input int n);
    int k;
    k = 0;
    while (((d == 0) ? alog0.size() : alog1.size()) < n && k < 200) begin
      step();
      k++;
    end
    chk("ack_timeout", 32'(k >= 200), 32'd0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    step();
    while ((busy[0] || busy[1]) && k < 100) begin
      step();
      k++;
    end
    chk("idle_timeout", 32'(busy[0] | busy[1]), 32'd0);
  endtask

  initial begin
    logic [W-1:0] sh, bits;
    rst_n   = 1'b0;
    clr     = 1'b1;
    auto_on = 1'b1;
    want    = 4'hF;
    req[0]  = 4'hF;
    req[1]  = '0;
    dat[0]  = {8'hC3, 8'h35, 8'h5A, 8'hAA};
    dat[1]  = {8'h0F, 8'h96, 8'h71, 8'hE8};

    // Reset held with all requests up; then round-robin 0,1,2,3,0.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_enable", 32'(en[0]), 32'd0);
    end
    @(negedge clk);
    clr   = 1'b0;
    rst_n = 1'b1;
    wait_acks(0, 5);
    want = '0;
    step();
    req[0] = '0;
    wait_idle();
    chk("rr_ack0", 32'(alog0[0]), 32'd0);
    chk("rr_ack1", 32'(alog0[1]), 32'd1);
    chk("rr_ack2", 32'(alog0[2]), 32'd2);
    chk("rr_ack3", 32'(alog0[3]), 32'd3);
    chk("rr_ack4", 32'(alog0[4]), 32'd0);
    chk("rr_word0", 32'(ackw0[0]), 32'h000000AA);
    chk("rr_word1", 32'(ackw0[1]), 32'h0000005A);
    chk("rr_space0", 32'(glog0[0]), 32'd3);
    chk("rr_space1", 32'(glog0[1]), 32'd3);

    // Single frame from requester 0 with 8'hAA.
    clear_logs();
    step();
    req[0] = 4'b0001;
    @(posedge clk);
    #1;
    chk("t2_write", 32'(wr[0]), 32'd1);
    chk("t2_data", 32'(sdat[0]), 32'h000000AA);
    chk("t2_ack", 32'(ack[0]), 32'd1);
    sh = sdat[0];
    bits = '0;
    req[0] = '0;
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      chk("t2_enable", 32'(en[0]), 32'd1);
      chk("t2_done", 32'(done[0]), (k == W) ? 32'd1 : 32'd0);
      bits = {bits[W-2:0], sh[W-1]};
      sh = sh << 1;
    end
    chk("t2_bits", 32'(bits), 32'h000000AA);
    @(posedge clk);
    #1;
    chk("t2_gap_busy", 32'(busy[0]), 32'd1);
    chk("t2_gap_en", 32'(en[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("t2_idle", 32'(busy[0]), 32'd0);

    // Pointer wrap: grant 2, then 0 before 1.
    clear_logs();
    step();
    req[0] = 4'b0100;
    wait_acks(0, 1);
    wait_idle();
    step();
    req[0] = 4'b0011;
    wait_acks(0, 3);
    wait_idle();
    chk("wrap_a", 32'(alog0[0]), 32'd2);
    chk("wrap_b", 32'(alog0[1]), 32'd0);
    chk("wrap_c", 32'(alog0[2]), 32'd1);

    // Reset in the 4th shift cycle, then requester 2 completes.
    clear_logs();
    step();
    req[0] = 4'b0100;
    @(posedge clk);
    #1;
    chk("t5_ack", 32'(ack[0]), 32'd4);
    repeat (4) @(posedge clk);
    #3;
    chk("t5_en_pre", 32'(en[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_en_async", 32'(en[0]), 32'd0);
    chk("t5_busy_async", 32'(busy[0]), 32'd0);
    chk("t5_done_async", 32'(done[0]), 32'd0);
    step();
    step();
    chk("t5_no_done", 32'(dlog0.size()), 32'd0);
    rst_n = 1'b1;
    wait_acks(0, 2);
    wait_idle();
    chk("t5_grant", 32'(alog0[1]), 32'd2);
    chk("t5_word", 32'(ackw0[1]), 32'h00000035);
    chk("t5_ndone", 32'(dlog0.size()), 32'd1);
    chk("t5_done_idx", 32'(dlog0[0]), 32'd2);

    // GAP_CYCLES=0: requester 1 withdraws before its grant.
    clear_logs();
    step();
    req[1] = 4'b0111;
    wait_acks(1, 1);
    req[1] = 4'b0100;
    wait_acks(1, 2);
    req[1] = '0;
    wait_idle();
    repeat (3) step();
    chk("g0_nacks", 32'(alog1.size()), 32'd2);
    chk("g0_ack_a", 32'(alog1[0]), 32'd0);
    chk("g0_ack_b", 32'(alog1[1]), 32'd2);
    chk("g0_space", 32'(glog1[0]), 32'd2);
    chk("g0_done_a", 32'(dlog1[0]), 32'd0);
    chk("g0_done_b", 32'(dlog1[1]), 32'd2);
    chk("g0_word_b", 32'(ackw1[1]), 32'h00000096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
